// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the seven-segment scan driver: display
//               geometry, scan counter width, the blank pattern, the
//               active-low hex->segment table and the leading-zero mask
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Eight digits, four scan counts per digit slot -> 5-bit counter.
  localparam int NDIG  = 8;
  localparam int CNT_W = 5;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Digit j is marked blank when it and every more-significant nibble are
  // zero. Digit 0 is never blanked so an all-zero value still shows "0".
  function automatic logic [NDIG-1:0] lead_zero_mask(input logic [31:0] value);
    logic [NDIG-1:0] mask;
    logic            all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int j = NDIG - 1; j >= 1; j--) begin
      all_zero = all_zero && (value[4*j +: 4] == 4'h0);
      mask[j]  = all_zero;
    end
    return mask;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Display-data and scan-output bundle of the seven-segment
//               scan driver.
//   data_in     32  eight hex nibbles, nibble j is digit j
//   load         1  one-cycle strobe, capture data_in into the shadow
//   counter      5  shared scan counter (down-counting)
//   temp_vector  7  active-low segment pattern for the next digit
//   an           8  active-low anodes
//   pending      1  shadow holds uncommitted data
//   frame_start  1  one-clk pulse on the commit tick
//   Modports: master (data source / observer), slave (the driver).
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if ();

  logic [31:0]                   data_in;
  logic                          load;
  logic [seg7_pkg::CNT_W-1:0]    counter;
  logic [6:0]                    temp_vector;
  logic [seg7_pkg::NDIG-1:0]     an;
  logic                          pending;
  logic                          frame_start;

  modport master (
    output data_in, load,
    input  counter, temp_vector, an, pending, frame_start
  );

  modport slave (
    input  data_in, load,
    output counter, temp_vector, an, pending, frame_start
  );

endinterface : seg7_scan_driver_if
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational hex nibble to active-low seven-segment pattern.
//   i_nibble  in   4  hex digit
//   o_seg     out  7  {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  wire logic [3:0] i_nibble,
  output logic      [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nibble];

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Scan driver for an 8-digit multiplexed active-low
//               seven-segment display. Produces the down-counting scan
//               counter, the next-digit segment pattern (temp_vector) and
//               the anodes, sequenced so a digit's cathodes are latched by
//               the cathode controller (at counter 4k+1) two ticks before
//               its anode turns on. Display data is double-buffered: load
//               writes a shadow, and the shadow is committed to the active
//               register on the tick leaving counter 3, so every frame
//               (digits 7..0) comes from one snapshot.
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   bus        slave modport of seg7_scan_driver_if
//   PRESCALE   clk cycles per scan tick, 1..65536
//   Optional   SEG7_LEAD_ZERO_BLANK_EN: blank leading-zero digits (digit 0
//              always shown), mask computed at commit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  seg7_scan_driver_if.slave       bus
);

  localparam logic [15:0]      c_PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_TOP = CNT_W'(31);
  localparam logic [CNT_W-1:0] c_CNT_COMMIT = CNT_W'(3);

  logic [15:0]      r_pre;
  logic [CNT_W-1:0] r_counter;
  logic [NDIG-1:0]  r_an;
  logic [6:0]       r_temp_vector;
  logic [31:0]      r_shadow;
  logic [31:0]      r_active;
  logic             r_pending;
  logic             r_frame_start;

  logic             w_tick;
  logic [15:0]      w_pre_next;
  logic [CNT_W-1:0] w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_commit;
  logic [31:0]      w_active_next;
  logic             w_pending_next;
  logic             w_fs_next;
  logic [2:0]       w_sel;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic [6:0]       w_tv_next;
  logic [NDIG-1:0]  w_an_next;

  // --------------------------------------------------------------------------
  // Tick and counter arithmetic
  // --------------------------------------------------------------------------
  assign w_tick     = (r_pre == c_PRE_MAX);
  assign w_pre_next = w_tick ? 16'd0 : r_pre + 16'd1;
  assign w_cnt_dec  = r_counter - c_CNT_ONE;  // 0 wraps to 31 naturally
  assign w_cnt_next = w_tick ? w_cnt_dec : r_counter;
  assign w_commit   = w_tick && (r_counter == c_CNT_COMMIT);

  // frame_start is registered but must be high during the commit tick
  // cycle itself, so it is computed one cycle ahead from the next state.
  assign w_fs_next  = (w_pre_next == c_PRE_MAX) && (w_cnt_next == c_CNT_COMMIT);

  // --------------------------------------------------------------------------
  // Shadow / active commit. A load coinciding with the commit tick bypasses
  // the shadow so the newest data is never left pending for a whole frame.
  // --------------------------------------------------------------------------
  always_comb begin
    w_active_next  = r_active;
    w_pending_next = r_pending;
    if (w_commit) begin
      if (bus.load) begin
        w_active_next = bus.data_in;
      end else if (r_pending) begin
        w_active_next = r_shadow;
      end
      w_pending_next = 1'b0;
    end else if (bus.load) begin
      w_pending_next = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-digit select: the pattern registered on this tick is for digit
  // (next_counter[4:2] - 1) mod 8, i.e. one slot ahead of its anode.
  // --------------------------------------------------------------------------
  assign w_sel    = w_cnt_dec[4:2] - 3'd1;
  assign w_nibble = r_active[{w_sel, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  logic [NDIG-1:0] r_blank;

  // Mask follows the active register; reset value matches active = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blank <= lead_zero_mask(32'h0);
    end else if (w_commit) begin
      r_blank <= lead_zero_mask(w_active_next);
    end
  end

  assign w_tv_next = r_blank[w_sel] ? SEG_BLANK : w_seg;
`else
  assign w_tv_next = w_seg;
`endif

  // --------------------------------------------------------------------------
  // Anodes: digit j is lit on counts 4j+2 and 4j+1; counts ending in 11 or
  // 00 are blanking slots giving the cathodes time to settle.
  // --------------------------------------------------------------------------
  generate
    for (genvar j = 0; j < NDIG; j++) begin : g_anode
      assign w_an_next[j] = !((w_cnt_dec[4:2] == 3'(j)) &&
                              (w_cnt_dec[1] ^ w_cnt_dec[0]));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre         <= 16'd0;
      r_counter     <= c_CNT_TOP;
      r_an          <= '1;
      r_temp_vector <= SEG_BLANK;
      r_shadow      <= 32'h0;
      r_active      <= 32'h0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pre         <= w_pre_next;
      r_frame_start <= w_fs_next;
      r_active      <= w_active_next;
      r_pending     <= w_pending_next;
      if (bus.load) begin
        r_shadow <= bus.data_in;
      end
      if (w_tick) begin
        r_counter     <= w_cnt_dec;
        r_an          <= w_an_next;
        r_temp_vector <= w_tv_next;
      end
    end
  end

  assign bus.counter     = r_counter;
  assign bus.an          = r_an;
  assign bus.temp_vector = r_temp_vector;
  assign bus.pending     = r_pending;
  assign bus.frame_start = r_frame_start;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver. A PRESCALE=1
//               instance is tracked every cycle by a behavioural model;
//               a PRESCALE=4 instance covers tick stretching and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic clk  = 1'b0;
  logic rst1 = 1'b0;
  logic rst4 = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus1 ();
  seg7_scan_driver_if bus4 ();

  seg7_scan_driver #(.PRESCALE(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1.slave));
  seg7_scan_driver #(.PRESCALE(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4.slave));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model --
  function automatic logic [6:0] ref_seg(input int h);
    case (h)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit digit_blank(input logic [31:0] v, input int d);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    return (d != 0) && ((v >> (4 * d)) == 32'h0);
`else
    return (v === 32'hx) && (d < 0);
`endif
  endfunction

  // Pattern registered when the counter moves to 'nxt'.
  function automatic logic [6:0] model_tv(input logic [31:0] v, input int nxt);
    int d;
    d = (nxt / 4 + 7) % 8;
    if (digit_blank(v, d)) return 7'h7F;
    return ref_seg(int'((v >> (4 * d)) & 32'hF));
  endfunction

  function automatic logic [7:0] ref_an(input int c);
    if (c % 4 == 1 || c % 4 == 2) return ~(8'd1 << (c / 4));
    return 8'hFF;
  endfunction

  int          m_cnt;
  logic [6:0]  m_tv;
  logic [31:0] m_shadow, m_active;
  logic        m_pend;

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      m_cnt <= 31; m_tv <= 7'h7F; m_shadow <= 32'h0; m_active <= 32'h0; m_pend <= 1'b0;
    end else begin
      m_cnt <= (m_cnt + 31) % 32;
      m_tv  <= model_tv(m_active, (m_cnt + 31) % 32);
      if (bus1.load) m_shadow <= bus1.data_in;
      if (m_cnt == 3) begin
        if (bus1.load) m_active <= bus1.data_in;
        else if (m_pend) m_active <= m_shadow;
        m_pend <= 1'b0;
      end else if (bus1.load) begin
        m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_counter", 32'(bus1.counter), m_cnt);
      chk("m_an", 32'(bus1.an), 32'(ref_an(m_cnt)));
      chk("m_temp_vector", 32'(bus1.temp_vector), 32'(m_tv));
      chk("m_pending", 32'(bus1.pending), 32'(m_pend));
      chk("m_frame_start", 32'(bus1.frame_start), 32'(m_cnt == 3));
      chk("m_one_anode", 32'($countones(~bus1.an) <= 1), 32'd1);
    end
  end

  // -------------------------------------------------------------- helpers --
  task automatic wait_c1(input logic [4:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (bus1.counter == target) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) begin
      n_total++;
      $display("FAIL wait_c1: counter never reached %0d", target);
    end
  endtask

  task automatic wait_c4(input logic [4:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (bus4.counter == target) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) begin
      n_total++;
      $display("FAIL wait_c4: counter never reached %0d", target);
    end
  endtask

  task automatic load1(input logic [31:0] d);
    bus1.data_in = d; bus1.load = 1'b1;
    @(negedge clk);
    bus1.load = 1'b0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  at_cnt;
    logic [6:0]  exp_tv;
  } vec_t;

  vec_t vecs[18];

  // ------------------------------------------------------------- stimulus --
  initial begin
    // Digit 0 is shown via temp_vector at counter 5.
    vecs[0]  = '{32'h00000000, 5'd5, 7'b1000000};
    vecs[1]  = '{32'h11111111, 5'd5, 7'b1111001};
    vecs[2]  = '{32'h22222222, 5'd5, 7'b0100100};
    vecs[3]  = '{32'h33333333, 5'd5, 7'b0110000};
    vecs[4]  = '{32'h44444444, 5'd5, 7'b0011001};
    vecs[5]  = '{32'h55555555, 5'd5, 7'b0010010};
    vecs[6]  = '{32'h66666666, 5'd5, 7'b0000010};
    vecs[7]  = '{32'h77777777, 5'd5, 7'b1111000};
    vecs[8]  = '{32'h88888888, 5'd5, 7'b0000000};
    vecs[9]  = '{32'h99999999, 5'd5, 7'b0010000};
    vecs[10] = '{32'hAAAAAAAA, 5'd5, 7'b0001000};
    vecs[11] = '{32'hBBBBBBBB, 5'd5, 7'b0000011};
    vecs[12] = '{32'hCCCCCCCC, 5'd5, 7'b1000110};
    vecs[13] = '{32'hDDDDDDDD, 5'd5, 7'b0100001};
    vecs[14] = '{32'hEEEEEEEE, 5'd5, 7'b0000110};
    vecs[15] = '{32'hFFFFFFFF, 5'd5, 7'b0001110};
    vecs[16] = '{32'h01234567, 5'd29, 7'b1111001};
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    vecs[17] = '{32'h01234567, 5'd1, 7'b1111111};
`else
    vecs[17] = '{32'h01234567, 5'd1, 7'b1000000};
`endif

    bus1.data_in = 32'h0; bus1.load = 1'b0;
    bus4.data_in = 32'h0; bus4.load = 1'b0;
    #1 rst1 = 1'b1; rst4 = 1'b1;
    #1;
    chk("rst_counter", 32'(bus1.counter), 32'd31);
    chk("rst_an", 32'(bus1.an), 32'hFF);
    chk("rst_tv", 32'(bus1.temp_vector), 32'h7F);
    chk("rst_pending", 32'(bus1.pending), 32'd0);
    chk("rst_fs", 32'(bus1.frame_start), 32'd0);

    @(negedge clk); #2 rst1 = 1'b0;
    #1;
    chk("rel_counter", 32'(bus1.counter), 32'd31);
    chk("rel_an", 32'(bus1.an), 32'hFF);
    chk("rel_tv", 32'(bus1.temp_vector), 32'h7F);
    chk_on = 1'b1;

    @(negedge clk);
    chk("tick1_counter", 32'(bus1.counter), 32'd30);
    chk("tick1_an", 32'(bus1.an), 32'h7F);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    chk("tick1_tv", 32'(bus1.temp_vector), 32'h7F);
`else
    chk("tick1_tv", 32'(bus1.temp_vector), 32'(7'b1000000));
`endif

    // Table-driven decode / digit ordering.
    for (int i = 0; i < 18; i++) begin
      load1(vecs[i].data);
      wait_c1(5'd2);           // first count after the commit tick
      wait_c1(vecs[i].at_cnt);
      chk($sformatf("vec%0d_tv", i), 32'(bus1.temp_vector), 32'(vecs[i].exp_tv));
    end
    wait_c1(5'd26);
    chk("an_at_26", 32'(bus1.an), 32'(8'b1011_1111));

    // Load mid-frame: held pending until the commit tick.
    wait_c1(5'd20);
    load1(32'h89ABCDEF);
    chk("mid_pending", 32'(bus1.pending), 32'd1);
    wait_c1(5'd3);
    chk("commit_fs", 32'(bus1.frame_start), 32'd1);
    chk("commit_pending_before", 32'(bus1.pending), 32'd1);
    @(negedge clk);
    chk("commit_pending_after", 32'(bus1.pending), 32'd0);
    wait_c1(5'd1);
    chk("new_digit7", 32'(bus1.temp_vector), 32'(7'b0000000));
    wait_c1(5'd29);
    chk("new_digit6", 32'(bus1.temp_vector), 32'(7'b0010000));

    // Load on the exact commit cycle: bypass.
    wait_c1(5'd3);
    load1(32'hFFFFFFFF);
    chk("bypass_pending", 32'(bus1.pending), 32'd0);
    chk("bypass_counter", 32'(bus1.counter), 32'd2);
    wait_c1(5'd1);
    chk("bypass_digit7", 32'(bus1.temp_vector), 32'(7'b0001110));

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    begin
      logic [4:0] bc[8];
      logic [6:0] be[8];
      bc = '{5'd1, 5'd29, 5'd25, 5'd21, 5'd17, 5'd13, 5'd9, 5'd5};
      be = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0001000, 7'b1000000, 7'b0010010};
      load1(32'h00000A05);
      wait_c1(5'd2);
      for (int k = 0; k < 8; k++) begin
        wait_c1(bc[k]);
        chk($sformatf("blank_digit%0d", 7 - k), 32'(bus1.temp_vector), 32'(be[k]));
      end
    end
`endif

    // Random traffic against the model, with a mid-frame reset.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bus1.data_in = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h00000FFF) : $urandom;
      bus1.load    = ($urandom_range(0, 7) == 0);
    end
    bus1.load = 1'b0;
    wait_c1(5'd10);
    load1(32'h5A5A5A5A);
    chk("pre_reset_pending", 32'(bus1.pending), 32'd1);
    #2 rst1 = 1'b1;
    @(negedge clk);
    chk("mid_reset_counter", 32'(bus1.counter), 32'd31);
    chk("mid_reset_pending", 32'(bus1.pending), 32'd0);
    #2 rst1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bus1.data_in = $urandom;
      bus1.load    = ($urandom_range(0, 5) == 0);
    end
    bus1.load = 1'b0;

    // PRESCALE=4: tick stretching and asynchronous reset.
    @(negedge clk); #2 rst4 = 1'b0;
    @(negedge clk);
    bus4.data_in = 32'h12345678; bus4.load = 1'b1;
    @(negedge clk);
    bus4.load = 1'b0;
    chk("p4_pending", 32'(bus4.pending), 32'd1);
    wait_c4(5'd13);
    wait_c4(5'd12);
    chk("p4_an_at_12", 32'(bus4.an), 32'hFF);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("p4_hold%0d", k), 32'(bus4.counter), 32'd12);
    end
    chk("p4_pending_12", 32'(bus4.pending), 32'd1);
    #1 rst4 = 1'b1;
    #1;
    chk("p4_rst_counter", 32'(bus4.counter), 32'd31);
    chk("p4_rst_an", 32'(bus4.an), 32'hFF);
    chk("p4_rst_tv", 32'(bus4.temp_vector), 32'h7F);
    chk("p4_rst_pending", 32'(bus4.pending), 32'd0);
    chk("p4_rst_fs", 32'(bus4.frame_start), 32'd0);
    @(negedge clk);
    #2 rst4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("p4_after_rst", 32'(bus4.counter), 32'd31);
    @(negedge clk);
    chk("p4_first_tick", 32'(bus4.counter), 32'd30);

    chk_on = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_seg7_scan_driver
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives the multiplexed 8-digit, active-low seven-segment display.
- Generates the shared 5-bit scan counter, the next-digit segment pattern `temp_vector` and the active-low anodes.
- The cathode controller consumes `counter` and `temp_vector` and latches cathodes at counter values 4k+1.
- This block sequences anodes so each digit's cathodes are stable two ticks before its anode turns on.
- 32-bit hex display data is double-buffered and committed only at a frame boundary, so there is no tearing.

Parameters:
- PRESCALE, 1: clk cycles per scan tick, range 1..2^16. The counter advances once per tick.
- NDIG, 8: digit count. Fixed at 8, because the counter is 5 bits with 4 counts per slot.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  32  eight hex nibbles; nibble j (bits 4j+3:4j) is digit j
- load  in  1  one-cycle strobe: capture data_in into the shadow register
- counter  out  5  scan counter, decrements once per tick, wraps 0 -> 31
- temp_vector  out  7  {g,f,e,d,c,b,a}, active-low pattern for the next digit
- an  out  8  anodes, active-low; an[j] enables digit j
- pending  out  1  shadow holds data not yet committed
- frame_start  out  1  one-clk pulse on the commit tick

Behaviour:
- Reset is asynchronous, active-high; all values below apply immediately:
  - counter = 5'b11111
  - an = 8'hFF
  - temp_vector = 7'b1111111
  - shadow = active = 32'h0
  - pending = 0, frame_start = 0
  - prescaler = 0
- Tick generation:
  - Prescaler counts 0..PRESCALE-1; tick is high on the cycle it equals PRESCALE-1.
  - PRESCALE=1 gives a tick every clk.
  - All scan registers change only on tick edges.
- Counter: on tick, counter <= counter-1, with 0 wrapping to 31.
- Anodes (registered):
  - On tick, an[j] <= 0 iff the next counter value is in {4j+2, 4j+1}; otherwise 1.
  - At most one anode is low at any time.
  - Counter values with [1:0] = 11 or 00 are blanking slots: an = FF.
- temp_vector (registered):
  - On tick, temp_vector <= seg(active nibble d), where d = (next_counter[4:2] + 7) mod 8.
  - Hence at counter = 4k+1, temp_vector holds digit (k-1) mod 8.
  - The cathode controller loads it at that count, two ticks before that digit's anode activates.
  - Digit 7 is loaded at counter = 1, then shown at counters 30 and 29.
- hex->seg encoding, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Shadow/commit:
  - load (any clk, no tick needed) writes shadow <= data_in and sets pending = 1.
  - Commit happens on the tick while counter == 3: if pending, active <= shadow and pending <= 0.
  - frame_start pulses on every commit tick, whether or not pending was set.
  - A frame therefore reads digits 7,6,...,0 from one snapshot.
- Simultaneous load and commit: active <= data_in (bypass), shadow <= data_in, pending = 0.
- Back-to-back loads: the last one wins.
- Reset mid-frame: the scan restarts at 31; pending data is discarded.

Optional Feature:
- Macro: SEG7_LEAD_ZERO_BLANK_EN.
- Defined:
  - At commit, a registered 8-bit blank mask is computed from the committed value.
  - Digit j is blanked iff all nibbles j..7 are zero and j != 0.
  - A blanked digit yields temp_vector 7'b1111111.
  - 0x00000000 shows a single "0" on digit 0.
- Undefined: all eight digits are always decoded; no mask logic exists.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111
  - the 16-entry hex->segment constants
  - NDIG = 8 and CNT_W = 5
- Sub-module seg7_hex_decode: purely combinational nibble -> 7-bit pattern, instantiated once on the digit-select mux output.

Test Plan:
- Reset, PRESCALE=1: after deassert, counter=31, an=FF, temp_vector=7F. After 1 tick, counter=30 and an=8'b0111_1111. Before the first commit, temp_vector is 7'b1000000 ("0" from active = 0) from the first tick on.
- Load 32'h01234567, wait for commit:
  - counter=29 -> temp_vector=1111001 (digit6=1)
  - counter=1 -> temp_vector=1000000 (digit7=0)
  - counter=26 -> an=8'b1011_1111
- Load at counter=20: pending=1 and the display keeps old data. At counter 3 the commit tick occurs with frame_start=1. The next frame shows the new data and pending=0.
- Load 32'hFFFFFFFF on the exact commit cycle: bypass; temp_vector at counter 1 = 0001110 and pending=0 afterwards.
- PRESCALE=4: counter holds each value for 4 clks. Assert reset at counter=12: outputs return asynchronously to their reset values within the same cycle.
- With SEG7_LEAD_ZERO_BLANK_EN, commit 32'h00000A05:
  - digits 7..3 show 7F
  - digit 2 shows 0001000
  - digit 1 shows 1000000
  - digit 0 shows 0010010
